fib_store_engine: RTL and testbench
===================================

# fib_store_engine

Parametrised Fibonacci generator/filter: on `go`, walks the sequence 1, 1, 2, 3, 5, … at one term per clock in a WIDTH-bit datapath and stores terms selected by `mode` (odd, even, all) into an internal DEPTH-entry buffer. It stops on buffer full or arithmetic overflow and flags which condition ended the run. The stored terms stay readable through an asynchronous read port. This block supersedes the fixed 8-bit odd-only datapath plus FSM plus RAM arrangement in the lab top level.

## Interface
- `WIDTH`, 8, term/datapath width in bits (≥ 2)
- `DEPTH`, 16, buffer entries (≥ 1); `AW = $clog2(DEPTH)` (min 1), `CW = $clog2(DEPTH+1)`
- `clk` in 1, sole clock, rising edge
- `reset` in 1, asynchronous, active-high; returns the block to IDLE
- `go` in 1, start request, sampled on the rising edge; level or pulse
- `mode` in 2, 00 odd terms, 01 even terms, 10 all terms, 11 treated as all; latched at start
- `rd_addr` in AW, read address
- `rd_data` out WIDTH, buffer[rd_addr] when rd_addr < count, else 0 (combinational)
- `count` out CW, number of terms stored in the current or last run
- `busy` out 1, high while in RUN
- `done` out 1, high while in DONE
- `ovf` out 1, run ended because the next term exceeds WIDTH bits
- `full` out 1, run ended because count reached DEPTH

## Operation
- States: IDLE, RUN, DONE. Registers: A, B (WIDTH), `last`, latched mode, count, ovf, full.
- IDLE or DONE with `go`=1: A←1, B←1, last←0, count←0, ovf←0, full←0, mode latched, go to RUN. `go` is ignored in RUN.
- Each RUN cycle evaluates term A:
  - qualifies = (odd: A[0]=1) | (even: A[0]=0) | (all: 1).
  - If it qualifies: write A at address count, then count←count+1.
  - Advance: A←B, B←(A+B)[WIDTH-1:0]. The carry out of A+B sets last←1.
  - Exit to DONE when any of these holds:
    - last was already 1 when the cycle began: ovf←1.
    - count becomes DEPTH after this write: full←1.
    - Both hold: ovf and full both set.
- Overflow rule: the term B held when the carry occurs is representable, so it is still evaluated in the following cycle. No truncated sum is ever evaluated.
- DONE holds all outputs and buffer contents until the next `go`. A new `go` clears count, so stale entries read as 0.
- Reset (any time, including mid-RUN): state IDLE, A=B=1, last=0, count=0, ovf=0, full=0, busy=0, done=0. `rd_data`=0 because count=0. Buffer contents are not cleared and are masked by count.
- Simultaneous `reset` and `go`: reset wins.

## Timing
- `go` sampled at edge 0. RUN occupies edges 1…T, one term per edge.
- Write and count update happen on the same edge as term evaluation.
- `busy` is high after edge 0 until the edge that enters DONE. `done` rises on that edge, with `ovf`/`full` valid in the same cycle.
- WIDTH=8 evaluates 13 terms (1…233). Cycle count T equals terms evaluated, unless full occurs earlier.
- Read latency 0: `rd_data` follows `rd_addr`/count combinationally, including a write completing on the current edge.

## Structure
- Package `fib_pkg`:
  - state enum {IDLE, RUN, DONE}
  - mode constants MODE_ODD=2'b00, MODE_EVEN=2'b01, MODE_ALL=2'b10
- Sub-module `fib_store_ram`, parameters WIDTH and DEPTH:
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port
- Top: FSM, A/B registers, adder with carry, count, flags, read masking.

## Test plan
- WIDTH=8, DEPTH=16, mode=00, pulse `go` → T=13. Buffer = 1,1,3,5,13,21,55,89,233. count=9, ovf=1, full=0. Addresses 9–15 read 0.
- Same configuration, mode=01 → buffer = 2,8,34,144. count=4, ovf=1, full=0.
- WIDTH=8, DEPTH=4, mode=10 → buffer = 1,1,2,3. count=4, full=1, ovf=0. `done` rises at edge 4.
- WIDTH=8, DEPTH=13, mode=10 → 13 writes ending with 233. full=1 and ovf=1 in the same cycle.
- Assert `reset` at edge 5 of a mode=10 run → busy=0, done=0, count=0, rd_data=0 for all addresses. A fresh `go` reproduces the full run. `go` held high during RUN has no effect.
- From DONE with mode=00 results, `go` with mode=01 → flags clear at edge 1. Final buffer reads 2,8,34,144, then 0 from address 4 upward.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci store engine.
package fib_pkg;

  // Controller states: waiting, generating terms, holding results.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Term selection filters; 2'b11 behaves like MODE_ALL.
  localparam logic [1:0] MODE_ODD  = 2'b00;
  localparam logic [1:0] MODE_EVEN = 2'b01;
  localparam logic [1:0] MODE_ALL  = 2'b10;

  // Buffer address width, never narrower than one bit.
  function automatic int fib_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width needed to hold a count from 0 to depth inclusive.
  function automatic int fib_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fib_store_engine_if.sv
// Control, status and read-port bundle of the Fibonacci store engine.
interface fib_store_engine_if
  import fib_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = fib_aw(DEPTH);
  localparam int CW = fib_cw(DEPTH);

  logic             go;
  logic [1:0]       mode;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             full;

  // Requester side: starts runs and reads the buffer.
  modport master (
    output go, mode, rd_addr,
    input  rd_data, count, busy, done, ovf, full
  );

  // Engine side.
  modport slave (
    input  go, mode, rd_addr,
    output rd_data, count, busy, done, ovf, full
  );

endinterface

// File: rtl/fib_store_ram.sv
// Term buffer: one synchronous write port, one combinational read port.
module fib_store_ram
  import fib_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [fib_aw(DEPTH)-1:0]  waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [fib_aw(DEPTH)-1:0]  raddr_i,
  output logic [WIDTH-1:0]          rdata_o
);
  localparam int AW = fib_aw(DEPTH);

  // Contents are deliberately never cleared; the engine masks stale
  // entries with its term count.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store one term per enabled clock edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses past DEPTH (non power-of-two depths) read as zero.
  assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/fib_store_engine.sv
// Fibonacci generator/filter: walks 1,1,2,3,5,... one term per clock,
// stores the terms selected by mode and stops on buffer full or on the
// first term whose successor no longer fits in WIDTH bits.
module fib_store_engine
  import fib_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  fib_store_engine_if.slave  bus
);
  localparam int AW = fib_aw(DEPTH);
  localparam int CW = fib_cw(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             last_q, last_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full_q, full_d;

  logic [WIDTH:0]   sum;
  logic             qualifies;
  logic             we;
  logic [CW-1:0]    count_inc;
  logic [WIDTH-1:0] ram_rdata;
  logic             in_range;

  // One extra bit keeps the carry that marks the next term as unrepresentable.
  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign count_inc = count_q + CW'(1);
  assign we        = (state_q == RUN) && qualifies;

  // Select the current term A according to the mode latched at start.
  always_comb begin
    qualifies = 1'b1;
    case (mode_q)
      MODE_ODD:  qualifies = a_q[0];
      MODE_EVEN: qualifies = ~a_q[0];
      default:   qualifies = 1'b1;
    endcase
  end

  // Controller and datapath next state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    mode_d  = mode_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    full_d  = full_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.go) begin
          state_d = RUN;
          a_d     = WIDTH'(1);
          b_d     = WIDTH'(1);
          last_d  = 1'b0;
          count_d = '0;
          ovf_d   = 1'b0;
          full_d  = 1'b0;
          mode_d  = bus.mode;
        end
      end
      RUN: begin
        if (we) begin
          count_d = count_inc;
        end
        a_d    = b_q;
        b_d    = sum[WIDTH-1:0];
        // B stays valid after the carry, so it is still evaluated once
        // more; the truncated sum never reaches A.
        last_d = last_q | sum[WIDTH];
        if (last_q) begin
          ovf_d = 1'b1;
        end
        if (we && (count_inc == CW'(DEPTH))) begin
          full_d = 1'b1;
        end
        if (last_q || (we && (count_inc == CW'(DEPTH)))) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= WIDTH'(1);
      b_q     <= WIDTH'(1);
      last_q  <= 1'b0;
      mode_q  <= MODE_ODD;
      count_q <= '0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
    end
  end

  // While in RUN count stays below DEPTH, so its low bits are a valid address.
  fib_store_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (a_q),
    .raddr_i (bus.rd_addr),
    .rdata_o (ram_rdata)
  );

  // Only entries written during the current or last run are visible.
  assign in_range    = (CW'(bus.rd_addr) < count_q);
  assign bus.rd_data = in_range ? ram_rdata : '0;
  assign bus.count   = count_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.ovf     = ovf_q;
  assign bus.full    = full_q;

endmodule

// File: tb/tb_fib_store_engine.sv
// Scoreboard bench: three engines (WIDTH=8; DEPTH 16, 4, 13) share go/mode/reset.
module tb_fib_store_engine;

  typedef struct packed {
    logic            is_reset;
    int              cnt;
    logic            ovf;
    logic            full;
    int              t;
    logic [15:0][7:0] terms;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       go;
  logic [1:0] mode;

  int n_vec = 0;
  int n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: list every Fibonacci term that fits in 8 bits, then walk
  // it, keeping the selected ones until the buffer fills or the list ends.
  function automatic exp_t model(input int depth, input logic [1:0] m);
    exp_t e;
    int fibs[$];
    int a;
    int b;
    int s;
    bit q;
    e = '0;
    a = 1;
    b = 1;
    while (a <= 255) begin
      fibs.push_back(a);
      s = a + b;
      a = b;
      b = s;
    end
    foreach (fibs[i]) begin
      if (m == 2'b00)      q = (fibs[i] % 2) == 1;
      else if (m == 2'b01) q = (fibs[i] % 2) == 0;
      else                 q = 1'b1;
      e.t = i + 1;
      if (q) begin
        e.terms[e.cnt] = 8'(fibs[i]);
        e.cnt = e.cnt + 1;
      end
      e.ovf  = (i == fibs.size() - 1);
      e.full = (e.cnt == depth);
      if (e.ovf || e.full) break;
    end
    return e;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int D  = (gi == 0) ? 16 : ((gi == 1) ? 4 : 13);
    localparam int AW = (D > 1) ? $clog2(D) : 1;

    fib_store_engine_if #(.WIDTH(8), .DEPTH(D)) bus ();
    exp_t sb_q[$];
    bit   mon_busy = 1'b0;

    assign bus.go   = go;
    assign bus.mode = mode;

    fib_store_engine #(.WIDTH(8), .DEPTH(D)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    // Monitor: pops one expectation per run (or reset) and checks it.
    initial begin : monitor
      exp_t   e;
      int     cyc;
      longint exp_rd;
      string  pfx;
      pfx = $sformatf("d%0d_", D);
      bus.rd_addr = '0;
      forever begin
        while (sb_q.size() == 0) @(negedge clk);
        e = sb_q.pop_front();
        mon_busy = 1'b1;
        @(negedge clk);
        if (!e.is_reset) begin
          cyc = 0;
          while (!bus.busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
          end
          chk({pfx, "start_busy"}, bus.busy, 1);
          chk({pfx, "start_done"}, bus.done, 0);
          chk({pfx, "start_ovf"}, bus.ovf, 0);
          chk({pfx, "start_full"}, bus.full, 0);
          chk({pfx, "start_count"}, bus.count, 0);
          cyc = 0;
          while (bus.busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
          end
          chk({pfx, "run_cycles"}, cyc, e.t);
          chk({pfx, "done"}, bus.done, 1);
          chk({pfx, "count"}, bus.count, e.cnt);
          chk({pfx, "ovf"}, bus.ovf, e.ovf);
          chk({pfx, "full"}, bus.full, e.full);
        end else begin
          chk({pfx, "rst_busy"}, bus.busy, 0);
          chk({pfx, "rst_done"}, bus.done, 0);
          chk({pfx, "rst_count"}, bus.count, 0);
          chk({pfx, "rst_ovf"}, bus.ovf, 0);
          chk({pfx, "rst_full"}, bus.full, 0);
        end
        for (int a = 0; a < (1 << AW); a++) begin
          bus.rd_addr = AW'(a);
          #1;
          exp_rd = (a < e.cnt) ? longint'(e.terms[a]) : 0;
          chk($sformatf("%srd_data[%0d]", pfx, a), bus.rd_data, exp_rd);
          @(negedge clk);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic push_all(input bit is_rst, input logic [1:0] m);
    exp_t e0;
    exp_t e1;
    exp_t e2;
    if (is_rst) begin
      e0 = '0; e1 = '0; e2 = '0;
      e0.is_reset = 1'b1; e1.is_reset = 1'b1; e2.is_reset = 1'b1;
    end else begin
      e0 = model(16, m);
      e1 = model(4, m);
      e2 = model(13, m);
    end
    g_cfg[0].sb_q.push_back(e0);
    g_cfg[1].sb_q.push_back(e1);
    g_cfg[2].sb_q.push_back(e2);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((g_cfg[0].mon_busy || g_cfg[0].sb_q.size() != 0 ||
            g_cfg[1].mon_busy || g_cfg[1].sb_q.size() != 0 ||
            g_cfg[2].mon_busy || g_cfg[2].sb_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("idle_within_budget", (n < 400) ? 1 : 0, 1);
  endtask

  // Start a run; go stays high for 'hold' extra edges, which RUN ignores.
  // mode is scrambled after the start edge to confirm it was latched.
  task automatic run_go(input logic [1:0] m, input int hold);
    wait_idle();
    @(posedge clk);
    #1;
    mode = m;
    go   = 1'b1;
    push_all(1'b0, m);
    @(posedge clk);
    #1 mode = 2'($urandom);
    repeat (hold) @(posedge clk);
    #1 go = 1'b0;
  endtask

  initial begin : stimulus
    reset = 1'b1;
    go    = 1'b0;
    mode  = 2'b00;
    push_all(1'b1, 2'b00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_go(2'b00, 0);
    run_go(2'b01, 0);
    run_go(2'b10, 0);

    // Reset in the middle of an all-terms run, with go still held.
    wait_idle();
    @(posedge clk);
    #1;
    mode = 2'b10;
    go   = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    go    = 1'b0;
    push_all(1'b1, 2'b00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_go(2'b10, 2);
    run_go(2'b00, 1);
    run_go(2'b01, 0);
    run_go(2'b11, 0);

    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_go(2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion, required completion within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
